stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter START_RUNNING, default 0, meaning the run state entered on reset (0 = PAUSED, 1 = RUNNING).
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port pause_db  input  1  debounced pause button level from debouncer.
REQ-005 The block SHALL have port reset_db  input  1  debounced clear button level from debouncer.
REQ-006 The block SHALL have port sw_adj  input  1  adjust-mode switch, 1 = adjust.
REQ-007 The block SHALL have port sw_sel  input  1  adjust field select: 0 = minutes, 1 = seconds.
REQ-008 The block SHALL have port tick_1hz  input  1  single-cycle count-enable pulse.
REQ-009 The block SHALL have port tick_2hz  input  1  single-cycle adjust-enable pulse.
REQ-010 The block SHALL have ports min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD time digits, registered.
REQ-011 The block SHALL have port running  output  1  1 when the FSM is in RUNNING, registered.
REQ-012 The block SHALL have port blink  output  1  adjust-field blank phase, registered.

Function
REQ-013 Edge detection SHALL use one register per button holding the previous-cycle level; pause_edge = pause_db & ~pause_prev, clear_edge = reset_db & ~reset_prev.
REQ-014 A level held high SHALL produce exactly one edge; a release SHALL produce no event.
REQ-015 The FSM SHALL have two states, PAUSED and RUNNING; pause_edge toggles the state on the same clk edge at which it is detected.
REQ-016 clear_edge SHALL zero all four digits and force PAUSED on the next clk edge, and SHALL take priority over pause_edge, tick_1hz and tick_2hz in the same cycle.
REQ-017 When RUNNING, sw_adj = 0 and tick_1hz = 1, the time SHALL advance one second, and digits SHALL update on the clk edge that samples the tick.
REQ-018 Counting SHALL carry sec_ones 9->0 into sec_tens, sec_tens 5->0 into min_ones, min_ones 9->0 into min_tens; 59:59 SHALL wrap to 00:00.
REQ-019 The time SHALL hold when PAUSED or when sw_adj = 1; tick_1hz SHALL then be ignored.
REQ-020 When sw_adj = 1 and tick_2hz = 1, the field selected by sw_sel SHALL increment by one in BCD, independent of run state.
REQ-021 An adjust increment SHALL wrap 59->00 with no carry into the other field.
REQ-022 tick_2hz SHALL be ignored when sw_adj = 0.
REQ-023 blink SHALL toggle on each tick_2hz while sw_adj = 1, and SHALL be forced to 0 on the clk edge after sw_adj is sampled 0.
REQ-024 If pause_edge and tick_1hz coincide, the tick SHALL be evaluated against the pre-toggle state.
REQ-025 A change on sw_sel or sw_adj SHALL take effect on the next sampled tick only, with no digit change of its own.
REQ-026 Digits SHALL never hold non-BCD values: ones <= 9 and tens <= 5.

Reset
REQ-027 While rst = 1: all digits 0, blink 0, state = START_RUNNING ? RUNNING : PAUSED, and running follows that state.
REQ-028 While rst = 1, pause_prev and reset_prev SHALL load the current pause_db and reset_db, so that a button held through reset produces no edge.
REQ-029 rst SHALL override all inputs, including a mid-count or mid-adjust operation.

Verification
REQ-030 rst 1 cycle, then pause_db high 1 cycle, then 3 tick_1hz pulses -> running = 1 and digits 00:03.
REQ-031 Load 00:59 via adjust, run, 1 tick_1hz -> 01:00; from 59:59, 1 tick -> 00:00.
REQ-032 pause_db held high 100 cycles while RUNNING -> exactly one toggle to PAUSED, and a following tick leaves digits unchanged.
REQ-033 reset_db edge coincident with pause_edge and tick_1hz at 12:34 -> 00:00, running = 0.
REQ-034 sw_adj = 1, sw_sel = 1, seconds = 58, 3 tick_2hz -> seconds 59, 00, 01 with minutes unchanged; blink toggles 3 times, then returns to 0 after sw_adj = 0.
REQ-035 pause_db held high across rst deassertion -> no toggle, and running = START_RUNNING.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch control: button edge detect, run/pause FSM, BCD counting and field adjust.
// All outputs are registered and reflect the inputs sampled one clk edge earlier; no backpressure.
module stopwatch_ctrl #(
    parameter bit START_RUNNING = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause_db,
    input  logic       reset_db,
    input  logic       sw_adj,
    input  logic       sw_sel,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       blink
);

    typedef enum logic {
        PAUSED  = 1'b0,
        RUNNING = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    localparam state_t RESET_STATE = START_RUNNING ? RUNNING : PAUSED;

    // Increment a 00..59 BCD field; the >= compares keep the field legal even from a bad value.
    function automatic bcd2_t bcd_inc(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.ones >= 4'd9) begin
            r.ones = 4'd0;
            r.tens = (v.tens >= 4'd5) ? 4'd0 : v.tens + 4'd1;
        end else begin
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

    function automatic logic bcd_is_max(input bcd2_t v);
        return (v.tens >= 4'd5) && (v.ones >= 4'd9);
    endfunction

    state_t state_q, state_d;
    bcd2_t  min_q, min_d;
    bcd2_t  sec_q, sec_d;
    logic   pause_prev_q, pause_prev_d;
    logic   reset_prev_q, reset_prev_d;
    logic   blink_q, blink_d;
    logic   running_q, running_d;
    logic   pause_edge;
    logic   clear_edge;

    assign pause_edge = pause_db & ~pause_prev_q;
    assign clear_edge = reset_db & ~reset_prev_q;

    always_comb begin
        state_d      = state_q;
        min_d        = min_q;
        sec_d        = sec_q;
        blink_d      = blink_q;
        pause_prev_d = pause_db;
        reset_prev_d = reset_db;

        if (clear_edge) begin
            state_d = PAUSED;
            min_d   = '0;
            sec_d   = '0;
            blink_d = sw_adj ? blink_q : 1'b0;
        end else begin
            if (pause_edge) begin
                state_d = (state_q == RUNNING) ? PAUSED : RUNNING;
            end
            if (sw_adj) begin
                if (tick_2hz) begin
                    blink_d = ~blink_q;
                    if (sw_sel) begin
                        sec_d = bcd_inc(sec_q);
                    end else begin
                        min_d = bcd_inc(min_q);
                    end
                end
            end else begin
                blink_d = 1'b0;
                // Tick is judged against the pre-toggle state so a coincident pause edge cannot steal it.
                if ((state_q == RUNNING) && tick_1hz) begin
                    sec_d = bcd_inc(sec_q);
                    if (bcd_is_max(sec_q)) begin
                        min_d = bcd_inc(min_q);
                    end
                end
            end
        end

        running_d = (state_d == RUNNING);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RESET_STATE;
            running_q    <= (RESET_STATE == RUNNING);
            min_q        <= '0;
            sec_q        <= '0;
            blink_q      <= 1'b0;
            // Load the live button levels so a press held through reset is not seen as an edge.
            pause_prev_q <= pause_db;
            reset_prev_q <= reset_db;
        end else begin
            state_q      <= state_d;
            running_q    <= running_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            blink_q      <= blink_d;
            pause_prev_q <= pause_prev_d;
            reset_prev_q <= reset_prev_d;
        end
    end

    assign min_tens = min_q.tens;
    assign min_ones = min_q.ones;
    assign sec_tens = sec_q.tens;
    assign sec_ones = sec_q.ones;
    assign running  = running_q;
    assign blink    = blink_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed stimulus pushes hand-computed expected outputs into a queue; a negedge monitor pops and compares.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       pause_db;
    logic       reset_db;
    logic       sw_adj;
    logic       sw_sel;
    logic       tick_1hz;
    logic       tick_2hz;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       blink;

    typedef struct packed {
        logic        run;
        logic        blk;
        logic [15:0] digits;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    stopwatch_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .pause_db (pause_db),
        .reset_db (reset_db),
        .sw_adj   (sw_adj),
        .sw_sel   (sw_sel),
        .tick_1hz (tick_1hz),
        .tick_2hz (tick_2hz),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .running  (running),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    // One clk edge; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // digits packed as MM:SS nibbles, e.g. 16'h1234 = 12:34
    task automatic chk(input string name, input logic run, input logic blk, input logic [15:0] digits);
        exp_t e;
        e.run    = run;
        e.blk    = blk;
        e.digits = digits;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  got;
            string n;
            e   = exp_q.pop_front();
            n   = name_q.pop_front();
            got.run    = running;
            got.blk    = blink;
            got.digits = {min_tens, min_ones, sec_tens, sec_ones};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL %s: got run=%0b blink=%0b time=%h:%h, want run=%0b blink=%0b time=%h:%h",
                         n, got.run, got.blk, got.digits[15:8], got.digits[7:0],
                         e.run, e.blk, e.digits[15:8], e.digits[7:0]);
            end
        end
    end

    initial begin
        rst = 1'b1; pause_db = 1'b0; reset_db = 1'b0; sw_adj = 1'b0;
        sw_sel = 1'b0; tick_1hz = 1'b0; tick_2hz = 1'b0;

        step(); step();
        chk("reset", 1'b0, 1'b0, 16'h0000);

        // start, then three counted seconds
        rst = 1'b0; pause_db = 1'b1;
        step(); pause_db = 1'b0;
        chk("start", 1'b1, 1'b0, 16'h0000);
        tick_1hz = 1'b1;
        step(); chk("tick1", 1'b1, 1'b0, 16'h0001);
        step(); chk("tick2", 1'b1, 1'b0, 16'h0002);
        step(); chk("tick3", 1'b1, 1'b0, 16'h0003);
        tick_1hz = 1'b0;

        // long press toggles once
        pause_db = 1'b1;
        step(); chk("hold_toggle", 1'b0, 1'b0, 16'h0003);
        repeat (99) step();
        chk("hold_100", 1'b0, 1'b0, 16'h0003);
        pause_db = 1'b0; tick_1hz = 1'b1;
        step(); tick_1hz = 1'b0;
        chk("paused_tick", 1'b0, 1'b0, 16'h0003);

        reset_db = 1'b1;
        step(); reset_db = 1'b0;
        chk("clear", 1'b0, 1'b0, 16'h0000);

        // adjust seconds to 59 while paused
        sw_adj = 1'b1; sw_sel = 1'b1;
        step(); chk("adj_enter", 1'b0, 1'b0, 16'h0000);
        tick_2hz = 1'b1;
        repeat (59) step();
        tick_2hz = 1'b0;
        chk("adj_sec59", 1'b0, 1'b1, 16'h0059);
        sw_adj = 1'b0; tick_1hz = 1'b1;
        step(); tick_1hz = 1'b0;
        chk("adj_exit_paused", 1'b0, 1'b0, 16'h0059);
        pause_db = 1'b1;
        step(); pause_db = 1'b0;
        chk("run_again", 1'b1, 1'b0, 16'h0059);
        sw_adj = 1'b1; tick_1hz = 1'b1;
        step(); tick_1hz = 1'b0;
        chk("adj_hold", 1'b1, 1'b0, 16'h0059);
        sw_adj = 1'b0; tick_1hz = 1'b1;
        step(); tick_1hz = 1'b0;
        chk("carry_min", 1'b1, 1'b0, 16'h0100);
        tick_2hz = 1'b1;
        step(); tick_2hz = 1'b0;
        chk("t2_ignored", 1'b1, 1'b0, 16'h0100);

        // load 59:59 while running, then full wrap
        sw_adj = 1'b1; sw_sel = 1'b0; tick_2hz = 1'b1;
        repeat (58) step();
        sw_sel = 1'b1;
        repeat (59) step();
        tick_2hz = 1'b0;
        chk("load_5959", 1'b1, 1'b1, 16'h5959);
        sw_adj = 1'b0; tick_1hz = 1'b1;
        step(); tick_1hz = 1'b0;
        chk("wrap_0000", 1'b1, 1'b0, 16'h0000);

        // clear beats pause edge and tick at 12:34
        sw_adj = 1'b1; sw_sel = 1'b0; tick_2hz = 1'b1;
        repeat (12) step();
        sw_sel = 1'b1;
        repeat (34) step();
        tick_2hz = 1'b0;
        chk("load_1234", 1'b1, 1'b0, 16'h1234);
        sw_adj = 1'b0;
        step(); chk("adj_off", 1'b1, 1'b0, 16'h1234);
        pause_db = 1'b1; reset_db = 1'b1; tick_1hz = 1'b1;
        step(); pause_db = 1'b0; reset_db = 1'b0; tick_1hz = 1'b0;
        chk("clear_prio", 1'b0, 1'b0, 16'h0000);

        // pause edge with coincident tick uses pre-toggle state
        step(); chk("idle", 1'b0, 1'b0, 16'h0000);
        pause_db = 1'b1; tick_1hz = 1'b1;
        step(); pause_db = 1'b0; tick_1hz = 1'b0;
        chk("toggle_tick_paused", 1'b1, 1'b0, 16'h0000);
        step(); chk("idle2", 1'b1, 1'b0, 16'h0000);
        pause_db = 1'b1; tick_1hz = 1'b1;
        step(); pause_db = 1'b0; tick_1hz = 1'b0;
        chk("toggle_tick_running", 1'b0, 1'b0, 16'h0001);

        // seconds adjust wrap 58 -> 59 -> 00 -> 01
        reset_db = 1'b1;
        step(); reset_db = 1'b0;
        chk("clear2", 1'b0, 1'b0, 16'h0000);
        sw_adj = 1'b1; sw_sel = 1'b1; tick_2hz = 1'b1;
        repeat (58) step();
        tick_2hz = 1'b0;
        chk("sec58", 1'b0, 1'b0, 16'h0058);
        tick_2hz = 1'b1;
        step(); chk("sec59", 1'b0, 1'b1, 16'h0059);
        step(); chk("sec00", 1'b0, 1'b0, 16'h0000);
        step(); chk("sec01", 1'b0, 1'b1, 16'h0001);
        tick_2hz = 1'b0; sw_adj = 1'b0;
        step(); chk("blink_off", 1'b0, 1'b0, 16'h0001);

        // minutes adjust wraps without touching seconds
        sw_adj = 1'b1; sw_sel = 1'b0; tick_2hz = 1'b1;
        repeat (60) step();
        tick_2hz = 1'b0;
        chk("min_wrap", 1'b0, 1'b0, 16'h0001);

        // reset mid-adjust with pause held across deassertion
        pause_db = 1'b1; tick_2hz = 1'b1; rst = 1'b1;
        step(); chk("rst_mid", 1'b0, 1'b0, 16'h0000);
        rst = 1'b0; tick_2hz = 1'b0;
        step(); chk("rst_release", 1'b0, 1'b0, 16'h0000);
        repeat (3) step();
        chk("rst_held", 1'b0, 1'b0, 16'h0000);
        pause_db = 1'b0; sw_adj = 1'b0;
        step(); chk("released", 1'b0, 1'b0, 16'h0000);
        pause_db = 1'b1;
        step(); pause_db = 1'b0;
        chk("post_rst_run", 1'b1, 1'b0, 16'h0000);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
